draw_canvas: RTL and testbench
==============================

# draw_canvas

Parametrised drawing canvas for the digit-input front end. Holds a GRID_W×GRID_H array of PIX_BITS-wide pixel intensities and a saturating cursor driven by held direction inputs. Supports pen/erase, a sequential clear engine, and a registered read port for the VGA renderer. A valid/ready stream dumps the whole image row-major to the inference datapath.

## Interface
- GRID_W, 28, grid width in cells
- GRID_H, 28, grid height in cells
- PIX_BITS, 1, intensity bits per cell
- INK_STEP, 2**PIX_BITS-1, saturating increment applied by pen per tick
- DELAY_MAX, 1250000, clock cycles per movement/draw tick
- XW/YW (localparams), $clog2(GRID_W)/$clog2(GRID_H); N = GRID_W*GRID_H
- CLOCK_50  in  1  system clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- mv_left, mv_right, mv_up, mv_down  in  1 each  held direction requests, active-high
- pen_down  in  1  ink at cursor on tick
- erase  in  1  zero cell at cursor on tick; overrides pen_down
- clear  in  1  single-cycle request: zero entire canvas
- dump_start  in  1  single-cycle request: stream canvas out
- cursor_x  out  XW  cursor column
- cursor_y  out  YW  cursor row
- rd_x  in  XW  read-port column
- rd_y  in  YW  read-port row
- rd_data  out  PIX_BITS  cell at (rd_x,rd_y), registered
- rd_is_cursor  out  1  (rd_x,rd_y) equals cursor, registered
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  PIX_BITS  stream pixel
- out_last  out  1  final beat (index N-1)
- busy  out  1  high in CLEAR or DUMP

## Operation
- FSM states: IDLE, CLEAR, DUMP. Reset enters CLEAR at address 0, which wipes the memory (memory itself has no reset).
- CLEAR: writes 0 to address a, a=0..N-1, one per cycle; at a=N-1 → IDLE. Movement, drawing and dump_start are ignored.
- IDLE transitions:
  - clear → CLEAR; clear wins over dump_start in the same cycle.
  - dump_start → DUMP with index 0.
- DUMP:
  - Beat k carries cell k, row-major (addr = y*GRID_W + x).
  - Index advances only on out_valid && out_ready.
  - out_data and out_last are held stable while stalled.
  - Handshake on beat N-1 → IDLE.
  - clear during DUMP aborts the dump (out_valid drops next cycle) → CLEAR.
  - Canvas and cursor are frozen.
- Tick counter:
  - Counts 0..DELAY_MAX-1 continuously in all states and wraps.
  - tick = (count == DELAY_MAX-1).
  - Tick actions apply only in IDLE.
- On tick in IDLE, movement:
  - x+1 if mv_right && x<GRID_W-1; x-1 if mv_left && x>0; left+right together: x unchanged.
  - Same rule for y: up decrements, down increments, range 0..GRID_H-1.
- On tick in IDLE, drawing uses the pre-move cursor cell:
  - erase: cell←0.
  - else pen_down: cell←min(cell+INK_STEP, 2**PIX_BITS-1), computed at PIX_BITS+1 bits then saturated.
  - Drawing and movement happen in the same tick.
- Read port:
  - rd_data is 0 when rd_x≥GRID_W or rd_y≥GRID_H.
  - rd_is_cursor is 0 out of range.
  - The read port is operational in all states and returns the memory contents as of the sampling edge.

## Timing
- Reset values:
  - cursor_x = GRID_W/2, cursor_y = GRID_H/2.
  - rd_data = 0, rd_is_cursor = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
  - busy = 1, state CLEAR, tick count 0.
- Clear: busy is high the cycle after the clear sample. Exactly N clear cycles; busy is low the cycle after the write to N-1.
- Dump: out_valid rises the cycle after dump_start is sampled. With out_ready held high, one beat per cycle for N cycles; busy falls the cycle after the last handshake.
- Cursor and drawn cell update on the tick edge. A write is visible on rd_data for a read sampled on any later edge.
- Read latency: exactly 1 cycle.
- resetn asserted mid-operation: all outputs return to reset values immediately; a clear restarts from address 0 on release.

## Test plan
- Reset release, GRID 28×28 → cursor (14,14), busy high exactly 784 cycles; afterwards rd_data=0 at (0,0), (27,27), (13,9).
- DELAY_MAX=4, mv_right held from x=14 → x steps every 4 cycles and stops at 27. Then mv_left+mv_right held → x stays 27.
- Cursor (3,5), pen_down one tick, dump with out_ready=1 → 784 beats. Beat 143 = 1, all others 0, out_last only on beat 783.
- PIX_BITS=4, INK_STEP=6, pen_down three ticks at one cell → reads 6, 12, 15. pen_down+erase on the next tick → 0.
- Dump with out_ready toggling 1,0,0,1 → data and out_last stable during stalls, no beat lost or duplicated, 784 handshakes total.
- clear asserted at beat 100 of a dump → out_valid low next cycle, busy stays high 784 cycles, canvas reads all 0, then returns to IDLE.

Source files
------------

// File: rtl/draw_canvas.sv
// draw_canvas: cursor-driven pixel canvas with a sequential clear engine,
// a registered read port and a row-major valid/ready dump stream.
module draw_canvas #(
    parameter  int unsigned GRID_W    = 28,
    parameter  int unsigned GRID_H    = 28,
    parameter  int unsigned PIX_BITS  = 1,
    parameter  int unsigned INK_STEP  = 2**PIX_BITS-1,
    parameter  int unsigned DELAY_MAX = 1250000,
    localparam int unsigned XW        = $clog2(GRID_W),
    localparam int unsigned YW        = $clog2(GRID_H),
    localparam int unsigned N         = GRID_W*GRID_H
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                mv_left,
    input  logic                mv_right,
    input  logic                mv_up,
    input  logic                mv_down,
    input  logic                pen_down,
    input  logic                erase,
    input  logic                clear,
    input  logic                dump_start,
    output logic [XW-1:0]       cursor_x,
    output logic [YW-1:0]       cursor_y,
    input  logic [XW-1:0]       rd_x,
    input  logic [YW-1:0]       rd_y,
    output logic [PIX_BITS-1:0] rd_data,
    output logic                rd_is_cursor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_BITS-1:0] out_data,
    output logic                out_last,
    output logic                busy
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
    localparam logic [PIX_BITS:0] PIX_MAX = {1'b0, {PIX_BITS{1'b1}}};
    localparam logic [PIX_BITS:0] INK     = INK_STEP[PIX_BITS:0];

    typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [XW-1:0]       cx_q, cx_d;
    logic [YW-1:0]       cy_q, cy_d;
    logic                ov_q, ov_d;
    logic [PIX_BITS-1:0] od_q, od_d;
    logic                ol_q, ol_d;
    logic [PIX_BITS-1:0] rd_data_q;
    logic                rd_cur_q;

    logic [PIX_BITS-1:0] mem [N];
    logic                we;
    logic [AW-1:0]       waddr;
    logic [PIX_BITS-1:0] wdata;

    logic                tick;
    logic [AW-1:0]       cur_addr, rd_addr;
    logic                rd_in_range;
    logic [PIX_BITS:0]   ink_sum;

    assign tick        = (cnt_q == CW'(DELAY_MAX-1));
    assign cur_addr    = AW'(cy_q) * AW'(GRID_W) + AW'(cx_q);
    assign rd_addr     = AW'(rd_y) * AW'(GRID_W) + AW'(rd_x);
    assign rd_in_range = (32'(rd_x) < GRID_W) && (32'(rd_y) < GRID_H);
    assign ink_sum     = {1'b0, mem[cur_addr]} + INK;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        cx_d    = cx_q;
        cy_d    = cy_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        we      = 1'b0;
        waddr   = cur_addr;
        wdata   = '0;
        case (state_q)
            CLEAR: begin
                we    = 1'b1;
                waddr = addr_q;
                if (addr_q == AW'(N-1)) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            IDLE: begin
                if (tick) begin
                    // Drawing targets the pre-move cell; the move lands on the same edge.
                    if (erase) begin
                        we = 1'b1;
                    end else if (pen_down) begin
                        we    = 1'b1;
                        wdata = (ink_sum > PIX_MAX) ? PIX_MAX[PIX_BITS-1:0] : ink_sum[PIX_BITS-1:0];
                    end
                    if (mv_right && !mv_left && cx_q != XW'(GRID_W-1)) cx_d = cx_q + XW'(1);
                    else if (mv_left && !mv_right && cx_q != '0)       cx_d = cx_q - XW'(1);
                    if (mv_down && !mv_up && cy_q != YW'(GRID_H-1))    cy_d = cy_q + YW'(1);
                    else if (mv_up && !mv_down && cy_q != '0)          cy_d = cy_q - YW'(1);
                end
                if (clear) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end else if (dump_start) begin
                    state_d = DUMP;
                    addr_d  = '0;
                    ov_d    = 1'b1;
                    od_d    = mem[0];
                    ol_d    = (N == 1);
                end
            end
            DUMP: begin
                if (clear) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    ov_d    = 1'b0;
                    od_d    = '0;
                    ol_d    = 1'b0;
                end else if (out_ready) begin
                    if (addr_q == AW'(N-1)) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        ov_d    = 1'b0;
                        od_d    = '0;
                        ol_d    = 1'b0;
                    end else begin
                        // Canvas is frozen in DUMP, so the next beat is fetched straight from memory.
                        addr_d = addr_q + AW'(1);
                        od_d   = mem[addr_q + AW'(1)];
                        ol_d   = (addr_q == AW'(N-2));
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= CLEAR;
            addr_q    <= '0;
            cnt_q     <= '0;
            cx_q      <= XW'(GRID_W/2);
            cy_q      <= YW'(GRID_H/2);
            ov_q      <= 1'b0;
            od_q      <= '0;
            ol_q      <= 1'b0;
            rd_data_q <= '0;
            rd_cur_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            ol_q      <= ol_d;
            rd_data_q <= rd_in_range ? mem[rd_addr] : '0;
            rd_cur_q  <= rd_in_range && (rd_x == cx_q) && (rd_y == cy_q);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (we) mem[waddr] <= wdata;
    end

    assign cursor_x     = cx_q;
    assign cursor_y     = cy_q;
    assign rd_data      = rd_data_q;
    assign rd_is_cursor = rd_cur_q;
    assign out_valid    = ov_q;
    assign out_data     = od_q;
    assign out_last     = ol_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_draw_canvas.sv
// Scoreboard bench for draw_canvas: a beat/read-level reference model queues
// expectations, a negedge monitor pops and compares them.
module tb_draw_canvas;
    localparam int W = 28, H = 28, PB = 4, STEP = 6, DM = 4, N = W*H;
    localparam int PMAX = 2**PB - 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic mv_left = 0, mv_right = 0, mv_up = 0, mv_down = 0;
    logic pen_down = 0, erase = 0, clear = 0, dump_start = 0, out_ready = 0;
    logic [4:0] rd_x = '0, rd_y = '0;
    logic [4:0] cursor_x, cursor_y;
    logic [PB-1:0] rd_data, out_data;
    logic rd_is_cursor, out_valid, out_last, busy;

    draw_canvas #(.GRID_W(W), .GRID_H(H), .PIX_BITS(PB), .INK_STEP(STEP), .DELAY_MAX(DM)) dut (
        .CLOCK_50(clk), .resetn(resetn),
        .mv_left(mv_left), .mv_right(mv_right), .mv_up(mv_up), .mv_down(mv_down),
        .pen_down(pen_down), .erase(erase), .clear(clear), .dump_start(dump_start),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .rd_x(rd_x), .rd_y(rd_y),
        .rd_data(rd_data), .rd_is_cursor(rd_is_cursor),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model
    typedef enum {M_IDLE, M_CLEAR, M_DUMP} mmode_t;
    typedef struct {int data; bit last;} beat_t;
    typedef struct {int data; bit cur;}  rd_t;
    mmode_t mode = M_CLEAR;
    int clr_left = N, beats_left = 0, kcount = 0, mx = W/2, my = H/2, idx;
    int mmem [N];
    beat_t exp_beats [$];
    rd_t   exp_rd [$];
    bit    tick_m;
    rd_t   rq;
    bit    in_rng;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mode = M_CLEAR; clr_left = N; kcount = 0; mx = W/2; my = H/2;
            exp_beats.delete(); exp_rd.delete();
        end else begin
            tick_m = (kcount % DM) == DM-1;
            kcount++;
            if (mode != M_CLEAR) begin
                in_rng = int'(rd_x) < W && int'(rd_y) < H;
                rq.data = in_rng ? mmem[int'(rd_y)*W + int'(rd_x)] : 0;
                rq.cur  = in_rng && int'(rd_x) == mx && int'(rd_y) == my;
                exp_rd.push_back(rq);
            end
            case (mode)
                M_CLEAR: begin
                    mmem[N - clr_left] = 0;
                    clr_left--;
                    if (clr_left == 0) mode = M_IDLE;
                end
                M_IDLE: begin
                    if (tick_m) begin
                        idx = my*W + mx;
                        if (erase) mmem[idx] = 0;
                        else if (pen_down) mmem[idx] = (mmem[idx] + STEP > PMAX) ? PMAX : mmem[idx] + STEP;
                        if (mv_right && !mv_left && mx < W-1) mx++;
                        else if (mv_left && !mv_right && mx > 0) mx--;
                        if (mv_down && !mv_up && my < H-1) my++;
                        else if (mv_up && !mv_down && my > 0) my--;
                    end
                    if (clear) begin
                        mode = M_CLEAR; clr_left = N;
                    end else if (dump_start) begin
                        mode = M_DUMP; beats_left = N;
                        for (int i = 0; i < N; i++) exp_beats.push_back('{mmem[i], i == N-1});
                    end
                end
                M_DUMP: begin
                    if (clear) begin
                        mode = M_CLEAR; clr_left = N; exp_beats.delete();
                    end else if (out_ready) begin
                        beats_left--;
                        if (beats_left == 0) mode = M_IDLE;
                    end
                end
            endcase
        end
    end

    // Monitor
    int beats_seen = 0;
    bit stalled = 0;
    logic [PB-1:0] stall_data;
    logic stall_last;
    rd_t   rm;
    beat_t bm;

    always @(negedge clk) begin
        if (!resetn) begin
            stalled = 0;
        end else begin
            chk("busy", busy, mode != M_IDLE);
            chk("cursor_x", cursor_x, mx);
            chk("cursor_y", cursor_y, my);
            chk("out_valid", out_valid, mode == M_DUMP);
            if (exp_rd.size() > 0) begin
                rm = exp_rd.pop_front();
                chk("rd_data", rd_data, rm.data);
                chk("rd_is_cursor", rd_is_cursor, rm.cur);
            end
            if (out_valid) begin
                if (stalled) begin
                    chk("stall_data", out_data, stall_data);
                    chk("stall_last", out_last, stall_last);
                end
                if (out_ready) begin
                    stalled = 0;
                    if (exp_beats.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL beat_extra: got beat %0d expected no beat", beats_seen);
                    end else begin
                        bm = exp_beats.pop_front();
                        chk("beat_data", out_data, bm.data);
                        chk("beat_last", out_last, bm.last);
                    end
                    beats_seen++;
                end else begin
                    stalled = 1; stall_data = out_data; stall_last = out_last;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    // Stimulus
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic set_rd(input int x, input int y);
        rd_x = 5'(x); rd_y = 5'(y);
    endtask

    task automatic count_busy(input string nm, input int exp_n);
        int n = 0;
        while (busy && n < 5000) begin n++; cyc(); end
        chk(nm, n, exp_n);
    endtask

    task automatic move_to(input int tx, input int ty);
        int n = 0;
        while ((int'(cursor_x) != tx || int'(cursor_y) != ty) && n < 1000) begin
            mv_right = int'(cursor_x) < tx; mv_left = int'(cursor_x) > tx;
            mv_down  = int'(cursor_y) < ty; mv_up   = int'(cursor_y) > ty;
            cyc(); n++;
        end
        {mv_left, mv_right, mv_up, mv_down} = '0;
        chk("move_to_x", cursor_x, tx);
        chk("move_to_y", cursor_y, ty);
    endtask

    task automatic pen_tick(input bit p, input bit e);
        pen_down = p; erase = e;
        repeat (DM) cyc();
        pen_down = 0; erase = 0;
    endtask

    // sel: 0 = ready high, 1 = random ready, 2 = ready pattern 1,0,0,1
    task automatic do_dump(input int sel);
        int start, n;
        start = beats_seen;
        dump_start = 1; out_ready = 1; cyc(); dump_start = 0;
        n = 0;
        while (busy && n < 20000) begin
            case (sel)
                0: out_ready = 1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (n % 4 == 0) || (n % 4 == 3);
            endcase
            cyc(); n++;
        end
        out_ready = 0;
        chk("dump_done", busy, 0);
        chk("dump_beats", beats_seen - start, N);
        chk("dump_leftover", exp_beats.size(), 0);
    endtask

    initial begin
        int start, n;
        int ink_exp [3] = '{6, 12, 15};
        repeat (3) cyc();
        chk("rst_cursor_x", cursor_x, W/2);
        chk("rst_cursor_y", cursor_y, H/2);
        chk("rst_busy", busy, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_is_cursor", rd_is_cursor, 0);
        resetn = 1;
        count_busy("reset_clear_cycles", N);

        set_rd(0, 0);   cyc(); chk("rd_0_0", rd_data, 0);
        set_rd(27, 27); cyc(); chk("rd_27_27", rd_data, 0);
        set_rd(13, 9);  cyc(); chk("rd_13_9", rd_data, 0);
        set_rd(28, 3);  cyc(); chk("rd_oor_x", rd_data, 0);
        set_rd(W/2, H/2); cyc(); chk("rd_cursor_hit", rd_is_cursor, 1);

        mv_right = 1; repeat (15*DM) cyc();
        chk("right_stop", cursor_x, W-1);
        mv_left = 1; repeat (3*DM) cyc();
        chk("left_right_hold", cursor_x, W-1);
        mv_left = 0; mv_right = 0;
        mv_up = 1; repeat (16*DM) cyc(); mv_up = 0;
        chk("up_stop", cursor_y, 0);

        move_to(3, 5);
        pen_tick(1, 0);
        set_rd(3, 5); cyc(); chk("pen_once", rd_data, STEP);
        do_dump(0);

        move_to(20, 20);
        set_rd(20, 20);
        for (int k = 0; k < 3; k++) begin
            pen_tick(1, 0); cyc();
            chk("ink_sat", rd_data, ink_exp[k]);
        end
        pen_tick(1, 1); cyc();
        chk("erase_wins", rd_data, 0);

        for (int i = 0; i < 400; i++) begin
            mv_left = 1'($urandom_range(0, 1)); mv_right = 1'($urandom_range(0, 1));
            mv_up = 1'($urandom_range(0, 1));   mv_down = 1'($urandom_range(0, 1));
            pen_down = ($urandom_range(0, 3) != 0); erase = ($urandom_range(0, 7) == 0);
            set_rd($urandom_range(0, 31), $urandom_range(0, 31));
            cyc();
        end
        {mv_left, mv_right, mv_up, mv_down, pen_down, erase} = '0;
        do_dump(1);
        do_dump(2);

        clear = 1; dump_start = 1; cyc(); clear = 0; dump_start = 0;
        chk("clear_beats_dump_valid", out_valid, 0);
        count_busy("idle_clear_cycles", N);

        move_to(7, 11);
        pen_tick(1, 0);
        dump_start = 1; out_ready = 1; cyc(); dump_start = 0;
        start = beats_seen; n = 0;
        while (beats_seen - start < 100 && n < 1000) begin cyc(); n++; end
        chk("abort_reached_100", beats_seen - start, 100);
        clear = 1; cyc(); clear = 0; out_ready = 0;
        chk("abort_valid_drop", out_valid, 0);
        count_busy("abort_clear_cycles", N);
        for (int i = 0; i < N; i++) begin
            set_rd(i % W, i / W); cyc();
            chk("abort_cell_zero", rd_data, 0);
        end

        move_to(1, 2);
        dump_start = 1; out_ready = 1; cyc(); dump_start = 0;
        repeat (30) cyc();
        resetn = 0; #1;
        chk("mid_rst_cursor_x", cursor_x, W/2);
        chk("mid_rst_cursor_y", cursor_y, H/2);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_rd_is_cursor", rd_is_cursor, 0);
        out_ready = 0;
        cyc(); resetn = 1;
        count_busy("mid_rst_clear_cycles", N);
        set_rd(13, 9); cyc();
        chk("post_rst_read", rd_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
